// File: rtl/pipe_pkg.sv
// Shared decode-stage definitions: control-word layout, fixed control
// words, opcode map and decode FSM state encoding.
package pipe_pkg;

    localparam int CTRL_W = 26;

    // Control-word field offsets (LSB of each field), MSB to LSB:
    // RW[25] SP[24:23] SW1[22] SW2[21] out_ld[20] MW[19] SM1[18:17]
    // SM2[16:15] ALU[14:11] Flags[10:7] BU[6:4] SE1[3] SE2[2] SE3[1] SE4[0]
    localparam int OFF_SE4   = 0;
    localparam int OFF_SE3   = 1;
    localparam int OFF_SE2   = 2;
    localparam int OFF_SE1   = 3;
    localparam int OFF_BU    = 4;
    localparam int OFF_FLAGS = 7;
    localparam int OFF_ALU   = 11;
    localparam int OFF_SM2   = 15;
    localparam int OFF_SM1   = 17;
    localparam int OFF_MW    = 19;
    localparam int OFF_OUTLD = 20;
    localparam int OFF_SW2   = 21;
    localparam int OFF_SW1   = 22;
    localparam int OFF_SP    = 23;
    localparam int OFF_RW    = 25;

    // Opcodes (instr[7:4])
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_RLC  = 4'h6;
    localparam logic [3:0] OP_SETC = 4'h7;
    localparam logic [3:0] OP_PUSH = 4'h8;
    localparam logic [3:0] OP_POP  = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_IN   = 4'hB;
    localparam logic [3:0] OP_LDM  = 4'hC;
    localparam logic [3:0] OP_LDD  = 4'hD;
    localparam logic [3:0] OP_STD  = 4'hE;
    localparam logic [3:0] OP_JZ   = 4'hF;

    // Field encodings
    localparam logic [3:0] ALU_PASSB = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_RLC   = 4'd6;
    localparam logic [3:0] ALU_SETC  = 4'd7;
    localparam logic [3:0] FL_ZNC    = 4'b0111;
    localparam logic [3:0] FL_ZN     = 4'b0011;
    localparam logic [3:0] FL_C      = 4'b0100;
    localparam logic [3:0] SP_DEC    = 4'b01;
    localparam logic [3:0] SP_INC    = 4'b10;
    localparam logic [3:0] SM1_SP    = 4'b01;
    localparam logic [3:0] SM1_IMM   = 4'b10;
    localparam logic [3:0] SM1_REG   = 4'b11;
    localparam logic [3:0] SM2_PC    = 4'b01;
    localparam logic [3:0] SM2_REG   = 4'b10;
    localparam logic [3:0] BU_JZ     = 4'b001;
    localparam logic [3:0] BU_LDPC   = 4'b111;
    localparam logic [3:0] ONE       = 4'b1;

    typedef enum logic [1:0] {
        ST_DECODE = 2'd0,
        ST_FETCH2 = 2'd1,
        ST_INT1   = 2'd2,
        ST_INT2   = 2'd3
    } dec_state_t;

    // Place a field value at its offset inside an otherwise-zero control word
    function automatic logic [CTRL_W-1:0] cw_fld(input logic [3:0] val, input int off);
        return CTRL_W'(val) << off;
    endfunction

    localparam logic [CTRL_W-1:0] CW_NOP      = '0;
    // Interrupt entry step 1: M[SP] <= PC, SP decrements
    localparam logic [CTRL_W-1:0] CW_INT_PUSH = cw_fld(SP_DEC, OFF_SP) | cw_fld(ONE, OFF_MW)
                                              | cw_fld(SM1_SP, OFF_SM1) | cw_fld(SM2_PC, OFF_SM2);
    // Interrupt entry step 2: PC <= M[imm] (imm carries the vector address)
    localparam logic [CTRL_W-1:0] CW_INT_LDPC = cw_fld(SM1_IMM, OFF_SM1) | cw_fld(BU_LDPC, OFF_BU);

endpackage

// File: rtl/decode_ctrl_rom.sv
// Opcode to control-word ROM, plus which register fields the opcode reads
// (used by the load-use hazard compare).
module decode_ctrl_rom
    import pipe_pkg::*;
(
    input  logic [3:0]        i_opc,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_uses_ra,
    output logic              o_uses_rb
);

    // Pure lookup; unlisted opcodes (NOP) decode to an all-zero word
    always_comb begin
        o_ctrl    = CW_NOP;
        o_uses_ra = 1'b0;
        o_uses_rb = 1'b0;
        case (i_opc)
            OP_MOV:  begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ALU_PASSB, OFF_ALU); o_uses_rb = 1'b1; end
            OP_ADD:  begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ALU_ADD, OFF_ALU) | cw_fld(FL_ZNC, OFF_FLAGS);
                           o_uses_ra = 1'b1; o_uses_rb = 1'b1; end
            OP_SUB:  begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ALU_SUB, OFF_ALU) | cw_fld(FL_ZNC, OFF_FLAGS);
                           o_uses_ra = 1'b1; o_uses_rb = 1'b1; end
            OP_AND:  begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ALU_AND, OFF_ALU) | cw_fld(FL_ZN, OFF_FLAGS);
                           o_uses_ra = 1'b1; o_uses_rb = 1'b1; end
            OP_OR:   begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ALU_OR, OFF_ALU) | cw_fld(FL_ZN, OFF_FLAGS);
                           o_uses_ra = 1'b1; o_uses_rb = 1'b1; end
            OP_RLC:  begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ALU_RLC, OFF_ALU) | cw_fld(FL_ZNC, OFF_FLAGS);
                           o_uses_ra = 1'b1; end
            OP_SETC: begin o_ctrl = cw_fld(ALU_SETC, OFF_ALU) | cw_fld(FL_C, OFF_FLAGS); end
            OP_PUSH: begin o_ctrl = cw_fld(SP_DEC, OFF_SP) | cw_fld(ONE, OFF_MW) | cw_fld(SM1_SP, OFF_SM1)
                                  | cw_fld(SM2_REG, OFF_SM2); o_uses_rb = 1'b1; end
            OP_POP:  begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(SP_INC, OFF_SP) | cw_fld(ONE, OFF_SW1)
                                  | cw_fld(SM1_SP, OFF_SM1); end
            OP_OUT:  begin o_ctrl = cw_fld(ONE, OFF_OUTLD); o_uses_rb = 1'b1; end
            OP_IN:   begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ONE, OFF_SW2); end
            OP_LDM:  begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ONE, OFF_SE1); end
            OP_LDD:  begin o_ctrl = cw_fld(ONE, OFF_RW) | cw_fld(ONE, OFF_SW1) | cw_fld(SM1_REG, OFF_SM1);
                           o_uses_rb = 1'b1; end
            OP_STD:  begin o_ctrl = cw_fld(ONE, OFF_MW) | cw_fld(SM1_REG, OFF_SM1) | cw_fld(SM2_REG, OFF_SM2);
                           o_uses_ra = 1'b1; o_uses_rb = 1'b1; end
            OP_JZ:   begin o_ctrl = cw_fld(BU_JZ, OFF_BU); o_uses_rb = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: fetched byte -> control word, ra/rb, immediate.
// Sequences two-byte instructions, inserts load-use bubbles, handles flush.
// Optional interrupt entry (INT1/INT2) is built only when DECODE_INT_EN
// is defined; otherwise intr is ignored and intr_ack is tied low.
// Outputs are combinational; the downstream D/Ex latch registers them.
module decode_stage
    import pipe_pkg::*;
#(
    parameter logic [3:0] TWO_BYTE_OPC = 4'hC,
    parameter logic [7:0] INT_VEC      = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        if_instr,
    input  logic              if_valid,
    input  logic              flush,
    input  logic              ex_mem_rd,
    input  logic [1:0]        ex_rd,
    input  logic              intr,
    output logic              stall_o,
    output logic              intr_ack,
    output logic              d_valid,
    output logic [CTRL_W-1:0] d_ctrl,
    output logic [1:0]        d_ra,
    output logic [1:0]        d_rb,
    output logic [7:0]        d_imm
);

    dec_state_t        r_state;
    dec_state_t        w_next;
    logic [7:0]        r_first;
    logic [3:0]        w_opc;
    logic [CTRL_W-1:0] w_rom_ctrl;
    logic              w_uses_ra;
    logic              w_uses_rb;
    logic              w_hazard;
    logic              w_intr_req;
    logic              w_two_byte;

`ifdef DECODE_INT_EN
    assign w_intr_req = intr;
`else
    logic w_unused_int;
    assign w_intr_req   = 1'b0;
    assign w_unused_int = ^{intr, INT_VEC};
`endif

    // In FETCH2 the ROM decodes the latched first byte, otherwise the live byte
    assign w_opc      = (r_state == ST_FETCH2) ? r_first[7:4] : if_instr[7:4];
    assign w_two_byte = (if_instr[7:4] == TWO_BYTE_OPC);

    decode_ctrl_rom u_rom (
        .i_opc     (w_opc),
        .o_ctrl    (w_rom_ctrl),
        .o_uses_ra (w_uses_ra),
        .o_uses_rb (w_uses_rb)
    );

    // Load-use: the load in Ex writes a register this instruction reads
    assign w_hazard = ex_mem_rd && ((w_uses_ra && (ex_rd == if_instr[3:2])) ||
                                    (w_uses_rb && (ex_rd == if_instr[1:0])));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_DECODE;
        else     r_state <= w_next;
    end

    // First byte of a two-byte instruction, captured on the DECODE->FETCH2 move
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              r_first <= '0;
        else if (r_state == ST_DECODE && w_next == ST_FETCH2) r_first <= if_instr;
    end

    // Next-state: flush and hazard hold DECODE; intr is only taken from DECODE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_DECODE: begin
                if (flush || w_hazard)          w_next = ST_DECODE;
                else if (w_intr_req)            w_next = ST_INT1;
                else if (if_valid && w_two_byte) w_next = ST_FETCH2;
            end
            ST_FETCH2: if (flush || if_valid) w_next = ST_DECODE;
`ifdef DECODE_INT_EN
            ST_INT1:   w_next = ST_INT2;
            ST_INT2:   w_next = ST_DECODE;
`endif
            default:   w_next = ST_DECODE;
        endcase
    end

    // Outputs: bubble by default, forced to bubble while reset is held
    always_comb begin
        stall_o  = 1'b0;
        intr_ack = 1'b0;
        d_valid  = 1'b0;
        d_ctrl   = CW_NOP;
        d_ra     = '0;
        d_rb     = '0;
        d_imm    = '0;
        if (!rst) begin
            case (r_state)
                ST_DECODE: begin
                    if (!flush) begin
                        if (w_hazard || w_intr_req) begin
                            stall_o = 1'b1;
                        end else if (if_valid && !w_two_byte) begin
                            d_valid = 1'b1;
                            d_ctrl  = w_rom_ctrl;
                            d_ra    = if_instr[3:2];
                            d_rb    = if_instr[1:0];
                        end
                    end
                end
                ST_FETCH2: begin
                    if (!flush && if_valid) begin
                        d_valid = 1'b1;
                        d_ctrl  = w_rom_ctrl;
                        d_ra    = r_first[3:2];
                        d_rb    = r_first[1:0];
                        d_imm   = if_instr;
                    end
                end
`ifdef DECODE_INT_EN
                ST_INT1: begin
                    d_valid = 1'b1;
                    d_ctrl  = CW_INT_PUSH;
                    stall_o = 1'b1;
                end
                ST_INT2: begin
                    d_valid  = 1'b1;
                    d_ctrl   = CW_INT_LDPC;
                    d_imm    = INT_VEC;
                    stall_o  = 1'b1;
                    intr_ack = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios then randomized
// traffic, expected outputs from a behavioural model of the decode rules.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  if_instr;
    logic        if_valid, flush, ex_mem_rd, intr;
    logic [1:0]  ex_rd;
    logic        stall_o, intr_ack, d_valid;
    logic [25:0] d_ctrl;
    logic [1:0]  d_ra, d_rb;
    logic [7:0]  d_imm;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid), .flush(flush),
        .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .intr(intr), .stall_o(stall_o),
        .intr_ack(intr_ack), .d_valid(d_valid), .d_ctrl(d_ctrl), .d_ra(d_ra),
        .d_rb(d_rb), .d_imm(d_imm)
    );

`ifdef DECODE_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic [25:0] c;
        logic [1:0]  ra;
        logic [1:0]  rb;
        logic [7:0]  imm;
        logic        st;
        logic        ack;
    } out_t;

    out_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_mode = 0;          // 0 decode, 1 awaiting 2nd byte, 2 push PC, 3 load PC
    logic [7:0] m_first = 8'h00;

    // Build a control word field by field (SE2..SE4 unused by this ISA)
    function automatic logic [25:0] mk(int rw, int sp, int sw1, int sw2, int ol, int mw,
                                       int sm1, int sm2, int alu, int fl, int bu, int se1);
        return {1'(rw), 2'(sp), 1'(sw1), 1'(sw2), 1'(ol), 1'(mw), 2'(sm1), 2'(sm2),
                4'(alu), 4'(fl), 3'(bu), 1'(se1), 3'b000};
    endfunction

    function automatic logic [25:0] ref_cw(int op);
        case (op)
            1:  return mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            2:  return mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 7, 0, 0);
            3:  return mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 7, 0, 0);
            4:  return mk(1, 0, 0, 0, 0, 0, 0, 0, 4, 3, 0, 0);
            5:  return mk(1, 0, 0, 0, 0, 0, 0, 0, 5, 3, 0, 0);
            6:  return mk(1, 0, 0, 0, 0, 0, 0, 0, 6, 7, 0, 0);
            7:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 4, 0, 0);
            8:  return mk(0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0);
            9:  return mk(1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            10: return mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            11: return mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            12: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            13: return mk(1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
            14: return mk(0, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0);
            15: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            default: return 26'd0;
        endcase
    endfunction

    // Drive one cycle of inputs, predict the outputs, queue the prediction
    task automatic step(input logic [7:0] ins, input logic v, input logic fl, input logic emr,
                        input logic [1:0] exr, input logic irq, input logic rs, output out_t e);
        int   op;
        logic haz;
        @(posedge clk);
        #1;
        if_instr = ins; if_valid = v; flush = fl; ex_mem_rd = emr; ex_rd = exr; intr = irq; rst = rs;
        e  = '0;
        op = int'(ins[7:4]);
        if (rs) begin
            m_mode  = 0;
            m_first = 8'h00;
        end else begin
            case (m_mode)
                0: begin
                    haz = emr && ((op inside {2, 3, 4, 5, 6, 14} && exr == ins[3:2]) ||
                                  (op inside {1, 2, 3, 4, 5, 8, 10, 13, 14, 15} && exr == ins[1:0]));
                    if (fl) begin end
                    else if (haz) e.st = 1'b1;
                    else if (INT_EN && irq) begin e.st = 1'b1; m_mode = 2; end
                    else if (!v) begin end
                    else if (op == 12) begin m_first = ins; m_mode = 1; end
                    else begin e.v = 1'b1; e.c = ref_cw(op); e.ra = ins[3:2]; e.rb = ins[1:0]; end
                end
                1: begin
                    if (fl) m_mode = 0;
                    else if (v) begin
                        e.v = 1'b1; e.c = ref_cw(12); e.ra = m_first[3:2]; e.rb = m_first[1:0];
                        e.imm = ins; m_mode = 0;
                    end
                end
                2: begin
                    e.v = 1'b1; e.c = mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0); e.st = 1'b1; m_mode = 3;
                end
                default: begin
                    e.v = 1'b1; e.c = mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 7, 0); e.imm = 8'h01;
                    e.st = 1'b1; e.ack = 1'b1; m_mode = 0;
                end
            endcase
        end
        q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the queue
    out_t mon_e, mon_a;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            mon_a = {d_valid, d_ctrl, d_ra, d_rb, d_imm, stall_o, intr_ack};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got v=%b ctrl=%h ra=%0d rb=%0d imm=%h stall=%b ack=%b need v=%b ctrl=%h ra=%0d rb=%0d imm=%h stall=%b ack=%b",
                         $time, mon_a.v, mon_a.c, mon_a.ra, mon_a.rb, mon_a.imm, mon_a.st, mon_a.ack,
                         mon_e.v, mon_e.c, mon_e.ra, mon_e.rb, mon_e.imm, mon_e.st, mon_e.ack);
            end
        end
    end

    initial begin
        out_t       e;
        logic [7:0] b;
        logic       bv, hold, irq, fl, emr, rs;
        int         irq_age;
        rst = 1'b1; if_instr = '0; if_valid = 1'b0; flush = 1'b0;
        ex_mem_rd = 1'b0; ex_rd = '0; intr = 1'b0;

        // Reset state, then release
        step(8'h00, 0, 0, 0, 2'd0, 0, 1, e);
        step(8'hC4, 1, 0, 0, 2'd0, 1, 1, e);
        step(8'h00, 0, 0, 0, 2'd0, 0, 0, e);
        // Two-byte LDM
        step(8'hC4, 1, 0, 0, 2'd0, 0, 0, e);
        step(8'h5A, 1, 0, 0, 2'd0, 0, 0, e);
        // Load-use on ra, then on rb, and a no-read opcode that matches ex_rd
        step(8'h29, 1, 0, 1, 2'd2, 0, 0, e);
        step(8'h29, 1, 0, 0, 2'd0, 0, 0, e);
        step(8'hE6, 1, 0, 1, 2'd2, 0, 0, e);
        step(8'hE6, 1, 0, 0, 2'd2, 0, 0, e);
        step(8'h9A, 1, 0, 1, 2'd2, 0, 0, e);
        // Flush in FETCH2, next byte is an opcode
        step(8'hC4, 1, 0, 0, 2'd0, 0, 0, e);
        step(8'h77, 1, 1, 0, 2'd0, 0, 0, e);
        step(8'h21, 1, 0, 0, 2'd0, 0, 0, e);
        // FETCH2 waits through an invalid cycle
        step(8'hC8, 1, 0, 0, 2'd0, 0, 0, e);
        step(8'h00, 0, 0, 0, 2'd0, 0, 0, e);
        step(8'h33, 1, 0, 0, 2'd0, 0, 0, e);
        // Flush and hazard together
        step(8'h29, 1, 1, 1, 2'd2, 0, 0, e);
        // Interrupt in DECODE, held instruction replayed
        step(8'h35, 1, 0, 0, 2'd0, 1, 0, e);
        step(8'h35, 1, 0, 0, 2'd0, 1, 0, e);
        step(8'h35, 1, 0, 0, 2'd0, 1, 0, e);
        step(8'h35, 1, 0, 0, 2'd0, 0, 0, e);
        // Interrupt raised during FETCH2 is deferred to DECODE
        step(8'hC4, 1, 0, 0, 2'd0, 0, 0, e);
        step(8'h00, 0, 0, 0, 2'd0, 1, 0, e);
        step(8'h5A, 1, 0, 0, 2'd0, 1, 0, e);
        step(8'h1B, 1, 0, 0, 2'd0, 1, 0, e);
        step(8'h1B, 1, 0, 0, 2'd0, 1, 0, e);
        step(8'h1B, 1, 0, 0, 2'd0, 1, 0, e);
        step(8'h1B, 1, 0, 0, 2'd0, 0, 0, e);
        // Reset during FETCH2, then a one-byte opcode issues directly
        step(8'hC4, 1, 0, 0, 2'd0, 0, 0, e);
        step(8'h5A, 1, 0, 0, 2'd0, 0, 1, e);
        step(8'h21, 1, 0, 0, 2'd0, 0, 0, e);

        // Random traffic; the fetch side holds its byte whenever a stall is predicted
        b = 8'h00; bv = 1'b0; hold = 1'b0; irq = 1'b0; irq_age = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                b  = 8'($urandom);
                bv = ($urandom % 8) != 0;
            end
            fl  = ($urandom % 10) == 0;
            emr = ($urandom % 4) == 0;
            rs  = ($urandom % 150) == 0;
            if (!irq && ($urandom % 30) == 0) begin irq = 1'b1; irq_age = 0; end
            step(b, bv, fl, emr, 2'($urandom), irq, rs, e);
            hold = e.st;
            if (irq) irq_age++;
            if (e.ack || irq_age > 12 || rs) irq = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, need 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
